pc_sequencer: RTL and testbench

//   Program-counter sequencer for the processor fetch stage.
//   - Holds the PC register and advances it by a configurable step.
//   - Supports stall, branch/jump load, and call/return through a small

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_sequencer_ras_stack.sv | 64 ++++++
 rtl/pc_sequencer.sv | 117 +++++++++++
 tb/tb_pc_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: constants and types shared by the program-counter sequencer.
//   DEFAULT_WIDTH      default PC / address width
//   DEFAULT_RESET_ADDR default PC value after reset
//   pc_src_t           source selected for the next PC value
package pc_pkg;

  localparam int DEFAULT_WIDTH      = 16;
  localparam int DEFAULT_RESET_ADDR = 0;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_BR   = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4
  } pc_src_t;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// ras_stack: circular return-address LIFO.
//   A push when full overwrites the oldest entry and the count stays at
//   RAS_DEPTH. A pop when empty is ignored. push and pop are never both
//   asserted by the owner.
// Ports:
//   clk        in  clock
//   reset      in  synchronous active-high reset (clears count and pointer)
//   push       in  store push_data as the new top
//   pop        in  discard the top entry
//   push_data  in  WIDTH value to store
//   top        out WIDTH most recently pushed live entry
//   empty      out no live entries
//   full       out RAS_DEPTH live entries
module ras_stack
  import pc_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  // ptr_reg addresses the next free slot; when full it points at the
  // oldest entry, so a push naturally overwrites it.
  logic [PW-1:0]    ptr_reg;
  logic [CW-1:0]    count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else if (push) begin
      ptr_reg <= ptr_reg + PW'(1);
      if (!full) begin
        count_reg <= count_reg + CW'(1);
      end
    end else if (pop && !empty) begin
      ptr_reg   <= ptr_reg - PW'(1);
      count_reg <= count_reg - CW'(1);
    end
  end

  assign top   = mem[ptr_reg - PW'(1)];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(RAS_DEPTH));

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the fetch stage.
//   Holds the PC, advances it by STEP, and supports stall, branch load and
//   call/return through a circular return-address stack.
//   Per-cycle priority: reset > stall > ret > call > branch > increment.
// Optional feature macro: PC_RAS_ERR_EN adds the sticky ras_err output
//   (set by a ret on empty or a call on full, cleared only by reset).
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   stall                 hold PC and RAS, drop all commands
//   branch_en             load branch_target
//   branch_target         branch / jump / call destination
//   call_en               push pc_plus, load branch_target
//   ret_en                pop RAS top into pc
//   pc                    registered program counter
//   pc_plus               combinational pc + STEP (link value)
//   ras_empty, ras_full   RAS occupancy flags
//   ras_err               sticky fault flag (PC_RAS_ERR_EN only)
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int STEP       = 1,
  parameter int RAS_DEPTH  = 4,
  parameter int RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             call_en,
  input  logic             ret_en,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             ras_empty,
  output logic             ras_full
`ifdef PC_RAS_ERR_EN
  ,
  output logic             ras_err
`endif
);

  pc_src_t          pc_src;
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;

  assign pc      = pc_reg;
  assign pc_plus = pc_reg + WIDTH'(STEP);

  // A ret on an empty stack falls back to a plain increment.
  always_comb begin
    pc_src = PC_INC;
    if (stall) begin
      pc_src = PC_HOLD;
    end else if (ret_en) begin
      pc_src = ras_empty ? PC_INC : PC_RET;
    end else if (call_en) begin
      pc_src = PC_CALL;
    end else if (branch_en) begin
      pc_src = PC_BR;
    end
  end

  always_comb begin
    pc_next = pc_plus;
    case (pc_src)
      PC_HOLD: pc_next = pc_reg;
      PC_INC:  pc_next = pc_plus;
      PC_BR:   pc_next = branch_target;
      PC_CALL: pc_next = branch_target;
      PC_RET:  pc_next = ras_top;
      default: pc_next = pc_plus;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= WIDTH'(RESET_ADDR);
    end else begin
      pc_reg <= pc_next;
    end
  end

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (pc_src == PC_CALL),
    .pop       (pc_src == PC_RET),
    .push_data (pc_plus),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

`ifdef PC_RAS_ERR_EN
  logic fault;
  logic ras_err_reg;

  assign fault = !stall && ((ret_en && ras_empty) ||
                            (!ret_en && call_en && ras_full));

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_err_reg <= 1'b0;
    end else if (fault) begin
      ras_err_reg <= 1'b1;
    end
  end

  assign ras_err = ras_err_reg;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic [15:0] branch_target = '0;
  logic        call_en = 1'b0;
  logic        ret_en = 1'b0;
  logic [15:0] pc;
  logic [15:0] pc_plus;
  logic        ras_empty;
  logic        ras_full;
`ifdef PC_RAS_ERR_EN
  logic        ras_err;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: plain integers and a queue, oldest entry at the front.
  int m_pc  = 0;
  int m_ras[$];
  bit m_err = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .pc            (pc),
    .pc_plus       (pc_plus),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full)
`ifdef PC_RAS_ERR_EN
    ,
    .ras_err       (ras_err)
`endif
  );

  task automatic model_step(input bit rs, st, rt, cl, br, input int tgt);
    if (rs) begin
      m_pc = 0;
      m_ras.delete();
      m_err = 0;
    end else if (st) begin
      // everything holds
    end else if (rt) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc  = (m_pc + 1) % 65536;
        m_err = 1;
      end
    end else if (cl) begin
      if (m_ras.size() == 4) begin
        void'(m_ras.pop_front());
        m_err = 1;
      end
      m_ras.push_back((m_pc + 1) % 65536);
      m_pc = tgt;
    end else if (br) begin
      m_pc = tgt;
    end else begin
      m_pc = (m_pc + 1) % 65536;
    end
  endtask

  task automatic check_model(input string tag);
    n_checks++;
    assert (pc === 16'(m_pc)) else begin
      n_fails++;
      $error("FAIL %s pc observed=%h expected=%h", tag, pc, 16'(m_pc));
    end
    n_checks++;
    assert (pc_plus === 16'((m_pc + 1) % 65536)) else begin
      n_fails++;
      $error("FAIL %s pc_plus observed=%h expected=%h", tag, pc_plus, 16'((m_pc + 1) % 65536));
    end
    n_checks++;
    assert (ras_empty === (m_ras.size() == 0)) else begin
      n_fails++;
      $error("FAIL %s ras_empty observed=%b expected=%b", tag, ras_empty, m_ras.size() == 0);
    end
    n_checks++;
    assert (ras_full === (m_ras.size() == 4)) else begin
      n_fails++;
      $error("FAIL %s ras_full observed=%b expected=%b", tag, ras_full, m_ras.size() == 4);
    end
`ifdef PC_RAS_ERR_EN
    n_checks++;
    assert (ras_err === m_err) else begin
      n_fails++;
      $error("FAIL %s ras_err observed=%b expected=%b", tag, ras_err, m_err);
    end
`endif
  endtask

  task automatic expect_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic expect_pc(input string tag, input logic [15:0] exp);
    n_checks++;
    assert (pc === exp) else begin
      n_fails++;
      $error("FAIL %s pc observed=%h expected=%h", tag, pc, exp);
    end
  endtask

  // One clock: drive at negedge, update the model at posedge, sample 1ns later.
  task automatic cycle(input string tag, input bit rs, st, rt, cl, br, input int tgt);
    @(negedge clk);
    reset = rs; stall = st; ret_en = rt; call_en = cl; branch_en = br;
    branch_target = 16'(tgt);
    @(posedge clk);
    model_step(rs, st, rt, cl, br, tgt);
    #1;
    $display("%0t %s rst=%0b stl=%0b ret=%0b call=%0b br=%0b tgt=%h -> pc=%h empty=%0b full=%0b",
             $time, tag, rs, st, rt, cl, br, 16'(tgt), pc, ras_empty, ras_full);
    check_model(tag);
  endtask

  initial begin
    // 1. reset, free run, wrap
    cycle("reset", 1, 0, 0, 0, 0, 0);
    expect_pc("reset_pc", 16'h0000);
    expect_bit("reset_empty", ras_empty, 1'b1);
    expect_bit("reset_full", ras_full, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cycle("inc", 0, 0, 0, 0, 0, 0);
      expect_pc("inc_pc", 16'(i));
    end
    cycle("br_ffff", 0, 0, 0, 0, 1, 16'hFFFF);
    cycle("wrap", 0, 0, 0, 0, 0, 0);
    expect_pc("wrap_pc", 16'h0000);

    // 2. stall with branch pending
    cycle("br_10", 0, 0, 0, 0, 1, 16'h0010);
    for (int i = 0; i < 3; i++) cycle("stall", 0, 1, 0, 0, 1, 16'h0200);
    expect_pc("stall_pc", 16'h0010);

    // 3. call then return
    cycle("call", 0, 0, 0, 1, 0, 16'h0100);
    expect_pc("call_pc", 16'h0100);
    expect_bit("call_nonempty", ras_empty, 1'b0);
    cycle("ret", 0, 0, 1, 0, 0, 0);
    expect_pc("ret_pc", 16'h0011);
    expect_bit("ret_empty", ras_empty, 1'b1);

    // 4. overflow then underflow
    for (int k = 1; k <= 5; k++) begin
      cycle("br_k", 0, 0, 0, 0, 1, 16 * k);
      cycle("call_k", 0, 0, 0, 1, 0, 16'h1000);
    end
    expect_bit("ovf_full", ras_full, 1'b1);
    cycle("ret1", 0, 0, 1, 0, 0, 0); expect_pc("ret1_pc", 16'h0051);
    cycle("ret2", 0, 0, 1, 0, 0, 0); expect_pc("ret2_pc", 16'h0041);
    cycle("ret3", 0, 0, 1, 0, 0, 0); expect_pc("ret3_pc", 16'h0031);
    cycle("ret4", 0, 0, 1, 0, 0, 0); expect_pc("ret4_pc", 16'h0021);
    cycle("ret5", 0, 0, 1, 0, 0, 0); expect_pc("ret5_pc", 16'h0022);
`ifdef PC_RAS_ERR_EN
    expect_bit("ret5_err", ras_err, 1'b1);
`endif

    // 5. ret beats call and branch
    cycle("reset5", 1, 0, 0, 0, 0, 0);
    cycle("br_32", 0, 0, 0, 0, 1, 16'h0032);
    cycle("call_500", 0, 0, 0, 1, 0, 16'h0500);
    cycle("all3", 0, 0, 1, 1, 1, 16'h0700);
    expect_pc("all3_pc", 16'h0033);
    expect_bit("all3_empty", ras_empty, 1'b1);

    // 6. reset with two entries live
    cycle("call_a", 0, 0, 0, 1, 0, 16'h0300);
    cycle("call_b", 0, 0, 0, 1, 0, 16'h0400);
    cycle("reset6", 1, 0, 1, 1, 1, 16'h0900);
    expect_pc("reset6_pc", 16'h0000);
    expect_bit("reset6_empty", ras_empty, 1'b1);
`ifdef PC_RAS_ERR_EN
    expect_bit("reset6_err", ras_err, 1'b0);
`endif

    // Random mix against the model.
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 65535)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
